// File: rtl/aes_ct_pkg.sv
// Shared sizing and FSM state type for the two-share ciphertext collector.
package aes_ct_pkg;
  localparam int NBYTES = 16;
  localparam int BW     = 8;
  localparam int CNT_W  = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } ct_state_t;
endpackage

// File: rtl/share_shift_reg.sv
// One share's byte-serial capture register. Load-first clears the history so
// a block never inherits bytes from the previous one.
module share_shift_reg #(
  parameter int BW     = 8,
  parameter int NBYTES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [BW-1:0]        din_i,
  output logic [NBYTES*BW-1:0] q_o
);
  localparam int W = NBYTES * BW;

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = {{(W-BW){1'b0}}, din_i};
    end else if (shift_i) begin
      q_d = {q_q[W-BW-1:0], din_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/aes_ct_collector.sv
// Collects the 16 ciphertext bytes of both shares after Done rises and offers
// the block over valid/ready; the shares are only XORed at the output port.
module aes_ct_collector
  import aes_ct_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 done,
  input  logic [BW-1:0]        sh1_in,
  input  logic [BW-1:0]        sh2_in,
  output logic [NBYTES*BW-1:0] ct_sh1,
  output logic [NBYTES*BW-1:0] ct_sh2,
  output logic [NBYTES*BW-1:0] ct,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic                 busy,
  output logic                 ovf,
  input  logic                 clr_ovf
);
  ct_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;
  logic             ovf_q, ovf_d;
  logic             start, load, shift;

  assign start = done & ~done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    load    = 1'b0;
    shift   = 1'b0;
    ovf_d   = clr_ovf ? 1'b0 : ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        shift = 1'b1;
        if (cnt_q == CNT_W'(NBYTES - 1)) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        // A transfer and a new Done edge in the same cycle restart seamlessly.
        if (ct_ready) begin
          if (start) begin
            load    = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done;
      ovf_q   <= ovf_d;
    end
  end

  share_shift_reg #(.BW(BW), .NBYTES(NBYTES)) u_sh1 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .din_i   (sh1_in),
    .q_o     (ct_sh1)
  );

  share_shift_reg #(.BW(BW), .NBYTES(NBYTES)) u_sh2 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .din_i   (sh2_in),
    .q_o     (ct_sh2)
  );

  assign ct       = ct_sh1 ^ ct_sh2;
  assign ct_valid = (state_q == HOLD);
  assign busy     = (state_q == COLLECT);
  assign ovf      = ovf_q;
endmodule
